// File: rtl/uart_arb_pkg.sv
// Shared types, widths and pointer helper for the UART register-bus arbiter.
package uart_arb_pkg;

    localparam int UART_ADDR_W = 4;
    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } arb_state_e;

    // Next round-robin start index; index 0 is skipped when it is reserved for fixed priority.
    function automatic int rr_next(input int winner, input int num_req, input bit skip_zero);
        int nxt;
        nxt = (winner + 1 >= num_req) ? 0 : winner + 1;
        if (skip_zero && nxt == 0) begin
            nxt = 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin winner selection for the UART bus arbiter.
// With UART_ARB_FIXED_PRI0_EN defined, requester 0 always wins and the rest rotate.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_oh_o,
    output logic [IDX_W-1:0]   win_idx_o,
    output logic               valid_o
);

    always_comb begin
        int cand;
        int start;
        logic [IDX_W-1:0] cand_idx;
        win_oh_o  = '0;
        win_idx_o = '0;
        valid_o   = 1'b0;
        cand      = 0;
        start     = 0;
        cand_idx  = '0;
`ifdef UART_ARB_FIXED_PRI0_EN
        start = (ptr_i == '0) ? 1 : int'(ptr_i);
        if (req_i[0]) begin
            valid_o     = 1'b1;
            win_oh_o[0] = 1'b1;
        end else begin
            for (int i = 0; i < NUM_REQ - 1; i++) begin
                cand     = 1 + ((start - 1 + i) % (NUM_REQ - 1));
                cand_idx = IDX_W'(cand);
                if (!valid_o && req_i[cand_idx]) begin
                    valid_o            = 1'b1;
                    win_oh_o[cand_idx] = 1'b1;
                    win_idx_o          = cand_idx;
                end
            end
        end
`else
        start = int'(ptr_i);
        for (int i = 0; i < NUM_REQ; i++) begin
            cand     = (start + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o            = 1'b1;
                win_oh_o[cand_idx] = 1'b1;
                win_idx_o          = cand_idx;
            end
        end
`endif
    end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter running one SETUP/STROBE/HOLD cycle on the UART core register bus per grant.
// Optional build macro: UART_ARB_FIXED_PRI0_EN (requester 0 gets fixed top priority).
module uart_bus_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int STROBE_CYC = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0]             rnw_i,
    input  logic [UART_ADDR_W*NUM_REQ-1:0] addr_i,
    input  logic [UART_DATA_W*NUM_REQ-1:0] wdata_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             done_o,
    output logic [UART_DATA_W-1:0]         rdata_o,
    output logic [UART_ADDR_W-1:0]         AddrBus_o,
    output logic                           n_ChipSelect_o,
    output logic                           n_rd_o,
    output logic                           n_we_o,
    output logic [UART_DATA_W-1:0]         DataBus_o,
    input  logic [UART_DATA_W-1:0]         DataBus_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STROBE_CYC + 1);

    arb_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [UART_DATA_W-1:0] rdata_q, rdata_d;
    logic [UART_ADDR_W-1:0] addr_q, addr_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   cs_n_q, cs_n_d;
    logic                   rd_n_q, rd_n_d;
    logic                   we_n_q, we_n_d;
    logic                   rnw_q, rnw_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_REQ-1:0]     win_oh;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_valid;
    logic [IDX_W-1:0]       ptr_next;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .valid_o   (win_valid)
    );

`ifdef UART_ARB_FIXED_PRI0_EN
    // A requester-0 win must not disturb the rotation among the others.
    assign ptr_next = (win_idx == '0) ? ptr_q
                                      : IDX_W'(rr_next(int'(win_idx), NUM_REQ, 1'b1));
`else
    assign ptr_next = IDX_W'(rr_next(int'(win_idx), NUM_REQ, 1'b0));
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cs_n_d  = cs_n_q;
        rd_n_d  = 1'b1;
        we_n_d  = 1'b1;
        rnw_d   = rnw_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                if (win_valid) begin
                    state_d = SETUP;
                    gnt_d   = win_oh;
                    cs_n_d  = 1'b0;
                    addr_d  = addr_i[int'(win_idx)*UART_ADDR_W +: UART_ADDR_W];
                    data_d  = wdata_i[int'(win_idx)*UART_DATA_W +: UART_DATA_W];
                    rnw_d   = rnw_i[win_idx];
                    ptr_d   = ptr_next;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_W'(1);
                rd_n_d  = !rnw_q;
                we_n_d  = rnw_q;
            end
            STROBE: begin
                // The read sample is taken while the strobe is still low on the bus.
                if (cnt_q == CNT_W'(STROBE_CYC)) begin
                    state_d = HOLD;
                    done_d  = gnt_q;
                    if (rnw_q) begin
                        rdata_d = DataBus_i;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    rd_n_d = !rnw_q;
                    we_n_d = rnw_q;
                end
            end
            HOLD: begin
                state_d = IDLE;
                gnt_d   = '0;
                cs_n_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            rnw_q   <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            we_n_q  <= we_n_d;
            rnw_q   <= rnw_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o          = gnt_q;
    assign done_o         = done_q;
    assign rdata_o        = rdata_q;
    assign AddrBus_o      = addr_q;
    assign DataBus_o      = data_q;
    assign n_ChipSelect_o = cs_n_q;
    assign n_rd_o         = rd_n_q;
    assign n_we_o         = we_n_q;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Scoreboard bench for uart_bus_arbiter: expected completions are queued at stimulus time
// and popped when done_o pulses. Also covers the UART_ARB_FIXED_PRI0_EN build.
module tb_uart_bus_arbiter;

    localparam int NUM_REQ    = 3;
    localparam int STROBE_CYC = 2;

    typedef struct {
        int         idx;
        logic       rnw;
        logic [7:0] rdata;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NUM_REQ-1:0]   req = '0;
    logic [NUM_REQ-1:0]   rnw = '0;
    logic [4*NUM_REQ-1:0] addr = '0;
    logic [8*NUM_REQ-1:0] wdata = '0;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [7:0]           rdata;
    logic [3:0]           addr_bus;
    logic                 n_cs;
    logic                 n_rd;
    logic                 n_we;
    logic [7:0]           data_bus_o;
    logic [7:0]           data_bus_i;

    logic [7:0] mem [16];
    exp_t       exp_q[$];
    logic [7:0] last_rdata = 8'h00;
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    // Simple UART core register file model answering reads.
    assign data_bus_i = mem[addr_bus];

    uart_bus_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .STROBE_CYC (STROBE_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req),
        .rnw_i          (rnw),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .gnt_o          (gnt),
        .done_o         (done),
        .rdata_o        (rdata),
        .AddrBus_o      (addr_bus),
        .n_ChipSelect_o (n_cs),
        .n_rd_o         (n_rd),
        .n_we_o         (n_we),
        .DataBus_o      (data_bus_o),
        .DataBus_i      (data_bus_i)
    );

    task automatic test_reset();
        rst = 1'b0;
        req = '1;
        rnw = '1;
        repeat (3) @(negedge clk);
        checks++; if (n_cs !== 1'b1) $display("[TB] FAIL reset_cs: got %b want 1", n_cs); else passes++;
        checks++; if (n_rd !== 1'b1) $display("[TB] FAIL reset_rd: got %b want 1", n_rd); else passes++;
        checks++; if (n_we !== 1'b1) $display("[TB] FAIL reset_we: got %b want 1", n_we); else passes++;
        checks++; if (gnt !== 3'b000) $display("[TB] FAIL reset_gnt: got %b want 000", gnt); else passes++;
        checks++; if (done !== 3'b000) $display("[TB] FAIL reset_done: got %b want 000", done); else passes++;
        checks++; if (rdata !== 8'h00) $display("[TB] FAIL reset_rdata: got %h want 00", rdata); else passes++;
        checks++; if (addr_bus !== 4'h0) $display("[TB] FAIL reset_addr: got %h want 0", addr_bus); else passes++;
        req = '0;
        rnw = '0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int   cyc = 0, cs_low = 0, rd_low = 0, we_low = 0, done_at = 0;
        exp_t e;
        rnw[0]     = 1'b1;
        addr[3:0]  = 4'h5;
        req[0]     = 1'b1;
        exp_q.push_back('{idx: 0, rnw: 1'b1, rdata: 8'hA7});
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (!n_cs) cs_low++;
            if (!n_rd) rd_low++;
            if (!n_we) we_low++;
            if (done !== 3'b000) begin
                e       = exp_q.pop_front();
                done_at = cyc;
                req[0]  = 1'b0;
                checks++; if (done !== 3'b001) $display("[TB] FAIL read_done_vec: got %b want 001", done); else passes++;
                checks++; if (rdata !== e.rdata) $display("[TB] FAIL read_rdata: got %h want %h", rdata, e.rdata); else passes++;
                last_rdata = e.rdata;
            end
        end
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL read_timeout: got %0d pending want 0", exp_q.size()); else passes++;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            if (!n_cs) cs_low++;
        end
        checks++; if (done_at != 2 + STROBE_CYC) $display("[TB] FAIL read_latency: got %0d want %0d", done_at, 2 + STROBE_CYC); else passes++;
        checks++; if (cs_low != 4) $display("[TB] FAIL read_cs_cycles: got %0d want 4", cs_low); else passes++;
        checks++; if (rd_low != 2) $display("[TB] FAIL read_rd_cycles: got %0d want 2", rd_low); else passes++;
        checks++; if (we_low != 0) $display("[TB] FAIL read_we_cycles: got %0d want 0", we_low); else passes++;
    endtask

    task automatic test_single_write();
        int   cyc = 0, we_low = 0, rd_low = 0;
        exp_t e;
        rnw[2]        = 1'b0;
        addr[11:8]    = 4'h3;
        wdata[23:16]  = 8'h5C;
        req[2]        = 1'b1;
        exp_q.push_back('{idx: 2, rnw: 1'b0, rdata: last_rdata});
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (!n_we) we_low++;
            if (!n_rd) rd_low++;
            if (cyc == 1) begin
                checks++; if (addr_bus !== 4'h3) $display("[TB] FAIL write_addr: got %h want 3", addr_bus); else passes++;
                checks++; if (data_bus_o !== 8'h5C) $display("[TB] FAIL write_data: got %h want 5c", data_bus_o); else passes++;
            end
            if (done !== 3'b000) begin
                e      = exp_q.pop_front();
                req[2] = 1'b0;
                checks++; if (done !== 3'b100) $display("[TB] FAIL write_done_vec: got %b want 100", done); else passes++;
                checks++; if (rdata !== e.rdata) $display("[TB] FAIL write_rdata_kept: got %h want %h", rdata, e.rdata); else passes++;
            end
        end
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL write_timeout: got %0d pending want 0", exp_q.size()); else passes++;
        exp_q.delete();
        @(negedge clk);
        checks++; if (we_low != 2) $display("[TB] FAIL write_we_cycles: got %0d want 2", we_low); else passes++;
        checks++; if (rd_low != 0) $display("[TB] FAIL write_rd_cycles: got %0d want 0", rd_low); else passes++;
    endtask

    task automatic test_contention();
        int         order[$];
        int         drop0_after;
        int         cyc = 0, n_done = 0, idle_run = 0;
        logic       prev_cs = 1'b1;
        logic [7:0] model_rd;
        logic [2:0] want_oh;
        exp_t       e;
`ifdef UART_ARB_FIXED_PRI0_EN
        order       = '{0, 0, 0, 1, 2, 1, 2};
        drop0_after = 3;
`else
        order       = '{0, 1, 2, 0, 1, 2};
        drop0_after = -1;
`endif
        // Requesters 0 and 2 read distinct registers; requester 1 writes and leaves rdata alone.
        model_rd = last_rdata;
        foreach (order[k]) begin
            if (order[k] == 0) model_rd = 8'h61;
            else if (order[k] == 2) model_rd = 8'hC4;
            exp_q.push_back('{idx: order[k], rnw: (order[k] != 1), rdata: model_rd});
        end
        rnw   = 3'b101;
        addr  = {4'hC, 4'h2, 4'h1};
        wdata = {8'h00, 8'h99, 8'h00};
        req   = '1;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (n_cs) begin
                idle_run++;
            end else if (prev_cs) begin
                if (n_done > 0) begin
                    checks++; if (idle_run != 1) $display("[TB] FAIL rr_idle_gap: got %0d want 1", idle_run); else passes++;
                end
                idle_run = 0;
            end
            prev_cs = n_cs;
            if (done !== 3'b000) begin
                e       = exp_q.pop_front();
                n_done++;
                want_oh = '0;
                want_oh[e.idx] = 1'b1;
                checks++; if (done !== want_oh) $display("[TB] FAIL rr_order_%0d: got %b want %b", n_done, done, want_oh); else passes++;
                checks++; if (rdata !== e.rdata) $display("[TB] FAIL rr_rdata_%0d: got %h want %h", n_done, rdata, e.rdata); else passes++;
                last_rdata = e.rdata;
                if (n_done == drop0_after) req[0] = 1'b0;
                if (exp_q.size() == 0) req = '0;
            end
        end
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL rr_timeout: got %0d pending want 0", exp_q.size()); else passes++;
        exp_q.delete();
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        int   cyc = 0;
        exp_t e;
        rnw[1]    = 1'b1;
        addr[7:4] = 4'h9;
        req[1]    = 1'b1;
        exp_q.push_back('{idx: 1, rnw: 1'b1, rdata: 8'h3C});
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                req[1]    = 1'b0;
                rnw[1]    = 1'b0;
                addr[7:4] = 4'hE;
            end
            if (cyc == 3) begin
                checks++; if (addr_bus !== 4'h9) $display("[TB] FAIL abort_addr_latched: got %h want 9", addr_bus); else passes++;
                checks++; if (n_rd !== 1'b0) $display("[TB] FAIL abort_rd_latched: got %b want 0", n_rd); else passes++;
            end
            if (done !== 3'b000) begin
                e = exp_q.pop_front();
                checks++; if (done !== 3'b010) $display("[TB] FAIL abort_done_vec: got %b want 010", done); else passes++;
                checks++; if (rdata !== e.rdata) $display("[TB] FAIL abort_rdata: got %h want %h", rdata, e.rdata); else passes++;
                last_rdata = e.rdata;
            end
        end
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL abort_timeout: got %0d pending want 0", exp_q.size()); else passes++;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int done_seen = 0;
        rnw[0]     = 1'b0;
        addr[3:0]  = 4'h7;
        wdata[7:0] = 8'h11;
        req[0]     = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (n_we !== 1'b0) $display("[TB] FAIL midrst_in_strobe: got %b want 0", n_we); else passes++;
        rst    = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        checks++; if (n_we !== 1'b1) $display("[TB] FAIL midrst_we: got %b want 1", n_we); else passes++;
        checks++; if (n_cs !== 1'b1) $display("[TB] FAIL midrst_cs: got %b want 1", n_cs); else passes++;
        checks++; if (gnt !== 3'b000) $display("[TB] FAIL midrst_gnt: got %b want 000", gnt); else passes++;
        checks++; if (rdata !== 8'h00) $display("[TB] FAIL midrst_rdata: got %h want 00", rdata); else passes++;
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done !== 3'b000) done_seen++;
        end
        checks++; if (done_seen != 0) $display("[TB] FAIL midrst_no_done: got %0d pulses want 0", done_seen); else passes++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 16 + i);
        mem[5]  = 8'hA7;
        mem[9]  = 8'h3C;
        mem[1]  = 8'h61;
        mem[12] = 8'hC4;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_abort();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
